cu_seq: RTL and testbench

- Next-generation control unit for the pipelined processor, placed in the decode stage.
- Decodes an OPCODE_W opcode into a registered control bundle with 1-cycle latency.
- Adds a micro-sequencer for multi-cycle operations: interrupt entry, CALL, RET and RTI. Each PC save/restore spans PC_WORDS stack beats, and the sequencer stalls fetch while a sequence is running.

---
 rtl/cu_pkg.sv | 61 ++++++
 rtl/cu_decode.sv | 67 ++++++
 rtl/cu_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_cu_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the decode-stage control unit: opcode classes,
// sequencer states, flag-destination codes and the control bundle.
package cu_pkg;

   localparam logic [2:0] CLS_ALU   = 3'b000;
   localparam logic [2:0] CLS_LOAD  = 3'b001;
   localparam logic [2:0] CLS_STORE = 3'b010;
   localparam logic [2:0] CLS_JCOND = 3'b011;
   localparam logic [2:0] CLS_IO    = 3'b101;
   localparam logic [2:0] CLS_STACK = 3'b111;

   localparam logic [4:0] PAT_MOV   = 5'b00100;
   localparam logic [4:0] PAT_CALL  = 5'b10110;
   localparam logic [4:0] PAT_RET   = 5'b11110;
   localparam logic [6:0] PAT_CARRY = 7'b1110000;

   localparam logic [1:0] FD_CARRY_CLR = 2'b00;
   localparam logic [1:0] FD_CARRY_SET = 2'b01;
   localparam logic [1:0] FD_NONE      = 2'b10;
   localparam logic [1:0] FD_ALU       = 2'b11;

   localparam logic [1:0] FLAG_ALWAYS  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PUSH_PC  = 3'd1,
      ST_PUSH_FLG = 3'd2,
      ST_VEC      = 3'd3,
      ST_POP_FLG  = 3'd4,
      ST_POP_PC   = 3'd5
   } state_t;

   typedef enum logic {
      MODE_INT  = 1'b0,
      MODE_CALL = 1'b1
   } mode_t;

   typedef struct packed {
      logic       wb;
      logic       alu;
      logic       imm;
      logic       selector;
      logic       mr;
      logic       mw;
      logic       jmp;
      logic       ior;
      logic       iow;
      logic [2:0] alu_ops;
      logic [1:0] flag_sel;
      logic [1:0] fd;
      logic       is_stack_op;
      logic       stack_op;
      logic       stack_pc;
      logic       stack_flags;
      logic [1:0] word_idx;
      logic       fetch_stall;
      logic       int_ack;
      logic       busy;
   } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational single-cycle opcode decode into the control bundle, plus
// flags telling the sequencer which multi-cycle operation an opcode starts.
module cu_decode
   import cu_pkg::*;
(
   input  logic [7:0] op,
   output ctrl_t      ctrl,
   output logic       is_call,
   output logic       is_ret,
   output logic       is_rti
);

   logic cls_alu_s;
   logic cls_load_s;
   logic cls_store_s;
   logic cls_jcond_s;
   logic cls_io_s;
   logic cls_stack_s;
   logic is_mov_s;
   logic is_carry_s;
   logic is_pop_s;
   logic is_push_s;
   logic is_ior_s;

   assign cls_alu_s   = (op[5:3] == CLS_ALU);
   assign cls_load_s  = (op[5:3] == CLS_LOAD);
   assign cls_store_s = (op[5:3] == CLS_STORE);
   assign cls_jcond_s = (op[5:3] == CLS_JCOND);
   assign cls_io_s    = (op[5:3] == CLS_IO);
   assign cls_stack_s = (op[5:3] == CLS_STACK);
   assign is_mov_s    = (op[7:3] == PAT_MOV);
   assign is_carry_s  = (op[7:1] == PAT_CARRY);
   assign is_pop_s    = cls_stack_s & op[0];
   assign is_push_s   = cls_stack_s & ~op[0];
   assign is_ior_s    = cls_io_s & ~op[0];

   assign is_call = (op[7:3] == PAT_CALL);
   assign is_ret  = (op[7:3] == PAT_RET) & ~op[0];
   assign is_rti  = (op[7:3] == PAT_RET) & op[0];

   // Build the single-cycle control bundle for the opcode.
   always_comb begin
      ctrl             = '0;
      ctrl.alu         = cls_alu_s;
      ctrl.alu_ops     = op[2:0];
      ctrl.imm         = (op[7:6] == 2'b01);
      ctrl.selector    = cls_alu_s & (op[7:6] == 2'b10);
      ctrl.ior         = is_ior_s;
      ctrl.iow         = cls_io_s & op[0];
      ctrl.wb          = cls_load_s | cls_alu_s | is_ior_s | is_pop_s |
                         (op[7:6] == 2'b01) | is_mov_s;
      ctrl.mr          = cls_load_s | is_pop_s;
      ctrl.mw          = cls_store_s | is_push_s;
      ctrl.jmp         = cls_jcond_s;
      ctrl.flag_sel    = op[1:0];
      ctrl.is_stack_op = cls_stack_s;
      ctrl.stack_op    = is_pop_s;
      if (is_carry_s) begin
         ctrl.fd = op[0] ? FD_CARRY_SET : FD_CARRY_CLR;
      end else if (cls_alu_s) begin
         ctrl.fd = FD_ALU;
      end else begin
         ctrl.fd = FD_NONE;
      end
   end

endmodule

// File: rtl/cu_seq.sv
// Decode-stage control unit: registered decode plus a micro-sequencer for
// interrupt entry, CALL, RET and RTI that drives multi-beat stack transfers.
module cu_seq
   import cu_pkg::*;
#(
   parameter int OPCODE_W     = 8,
   parameter int PC_WORDS     = 2,
   parameter int FLAGS_ON_INT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                opcode_valid,
   input  logic                int_req,
   input  logic                stall_in,
   output logic                wb,
   output logic                alu,
   output logic                imm,
   output logic                selector,
   output logic                mr,
   output logic                mw,
   output logic                jmp,
   output logic                ior,
   output logic                iow,
   output logic [2:0]          alu_ops,
   output logic [1:0]          flag_sel,
   output logic [1:0]          fd,
   output logic                is_stack_op,
   output logic                stack_op,
   output logic                stack_pc,
   output logic                stack_flags,
   output logic [1:0]          word_idx,
   output logic                fetch_stall,
   output logic                int_ack,
   output logic                busy
);

   localparam logic [1:0] LAST_BEAT = 2'(PC_WORDS - 1);

   state_t state_r, next_state_s;
   mode_t  mode_r, next_mode_s;
   logic [1:0] beat_r, next_beat_s;
   logic   int_pending_r;
   logic   take_int_s;
   ctrl_t  dec_s, out_s, out_r;
   logic   is_call_s, is_ret_s, is_rti_s;

   cu_decode u_decode (
      .op      (opcode[7:0]),
      .ctrl    (dec_s),
      .is_call (is_call_s),
      .is_ret  (is_ret_s),
      .is_rti  (is_rti_s)
   );

   // Sequencer state, beat counter, mode and sticky interrupt request.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         beat_r        <= 2'd0;
         mode_r        <= MODE_INT;
         int_pending_r <= 1'b0;
      end else if (stall_in) begin
         int_pending_r <= int_pending_r | int_req;
      end else begin
         state_r       <= next_state_s;
         beat_r        <= next_beat_s;
         mode_r        <= next_mode_s;
         int_pending_r <= take_int_s ? 1'b0 : (int_pending_r | int_req);
      end
   end

   // Next-state logic; an interrupt outranks any opcode in IDLE.
   always_comb begin
      next_state_s = state_r;
      next_beat_s  = beat_r;
      next_mode_s  = mode_r;
      take_int_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (int_req | int_pending_r) begin
               take_int_s   = 1'b1;
               next_state_s = ST_PUSH_PC;
               next_mode_s  = MODE_INT;
               next_beat_s  = 2'd0;
            end else if (opcode_valid & is_call_s) begin
               next_state_s = ST_PUSH_PC;
               next_mode_s  = MODE_CALL;
               next_beat_s  = 2'd0;
            end else if (opcode_valid & is_rti_s) begin
               next_state_s = ST_POP_FLG;
            end else if (opcode_valid & is_ret_s) begin
               next_state_s = ST_POP_PC;
               next_beat_s  = LAST_BEAT;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_PUSH_PC: begin
            if (beat_r == LAST_BEAT) begin
               next_beat_s = 2'd0;
               if (mode_r == MODE_CALL) begin
                  next_state_s = ST_IDLE;
               end else if (FLAGS_ON_INT != 0) begin
                  next_state_s = ST_PUSH_FLG;
               end else begin
                  next_state_s = ST_VEC;
               end
            end else begin
               next_beat_s = beat_r + 2'd1;
            end
         end
         ST_PUSH_FLG: next_state_s = ST_VEC;
         ST_VEC:      next_state_s = ST_IDLE;
         ST_POP_FLG: begin
            next_state_s = ST_POP_PC;
            next_beat_s  = LAST_BEAT;
         end
         ST_POP_PC: begin
            if (beat_r == 2'd0) begin
               next_state_s = ST_IDLE;
            end else begin
               next_beat_s = beat_r - 2'd1;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
            next_beat_s  = 2'd0;
         end
      endcase
   end

   // Output bundle for the cycle being executed; registered below.
   always_comb begin
      out_s = '0;
      case (state_r)
         ST_IDLE: begin
            if (take_int_s) begin
               out_s.int_ack     = 1'b1;
               out_s.fetch_stall = 1'b1;
            end else if (opcode_valid) begin
               out_s             = dec_s;
               out_s.fetch_stall = (next_state_s != ST_IDLE);
            end else begin
               out_s = '0;
            end
         end
         ST_PUSH_PC: begin
            out_s.mw          = 1'b1;
            out_s.stack_pc    = 1'b1;
            out_s.is_stack_op = 1'b1;
            out_s.word_idx    = beat_r;
            out_s.busy        = 1'b1;
            if ((beat_r == LAST_BEAT) && (mode_r == MODE_CALL)) begin
               out_s.jmp      = 1'b1;
               out_s.flag_sel = FLAG_ALWAYS;
            end else begin
               out_s.fetch_stall = 1'b1;
            end
         end
         ST_PUSH_FLG: begin
            out_s.mw          = 1'b1;
            out_s.stack_flags = 1'b1;
            out_s.is_stack_op = 1'b1;
            out_s.busy        = 1'b1;
            out_s.fetch_stall = 1'b1;
         end
         ST_VEC: begin
            out_s.mr   = 1'b1;
            out_s.jmp  = 1'b1;
            out_s.busy = 1'b1;
         end
         ST_POP_FLG: begin
            out_s.mr          = 1'b1;
            out_s.stack_flags = 1'b1;
            out_s.is_stack_op = 1'b1;
            out_s.stack_op    = 1'b1;
            out_s.busy        = 1'b1;
            out_s.fetch_stall = 1'b1;
         end
         ST_POP_PC: begin
            out_s.mr          = 1'b1;
            out_s.stack_pc    = 1'b1;
            out_s.is_stack_op = 1'b1;
            out_s.stack_op    = 1'b1;
            out_s.word_idx    = beat_r;
            out_s.busy        = 1'b1;
            if (beat_r == 2'd0) begin
               out_s.jmp      = 1'b1;
               out_s.flag_sel = FLAG_ALWAYS;
            end else begin
               out_s.fetch_stall = 1'b1;
            end
         end
         default: out_s = '0;
      endcase
   end

   // Output register; holds its value while the pipeline is frozen.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_r <= '0;
      end else if (!stall_in) begin
         out_r <= out_s;
      end else begin
         out_r <= out_r;
      end
   end

   assign wb          = out_r.wb;
   assign alu         = out_r.alu;
   assign imm         = out_r.imm;
   assign selector    = out_r.selector;
   assign mr          = out_r.mr;
   assign mw          = out_r.mw;
   assign jmp         = out_r.jmp;
   assign ior         = out_r.ior;
   assign iow         = out_r.iow;
   assign alu_ops     = out_r.alu_ops;
   assign flag_sel    = out_r.flag_sel;
   assign fd          = out_r.fd;
   assign is_stack_op = out_r.is_stack_op;
   assign stack_op    = out_r.stack_op;
   assign stack_pc    = out_r.stack_pc;
   assign stack_flags = out_r.stack_flags;
   assign word_idx    = out_r.word_idx;
   assign fetch_stall = out_r.fetch_stall;
   assign int_ack     = out_r.int_ack;
   assign busy        = out_r.busy;

endmodule

// File: tb/tb_cu_seq.sv
// Directed bench for cu_seq (PC_WORDS = 2, FLAGS_ON_INT = 1) with
// hand-computed expected control bundles per cycle.
module tb_cu_seq;

   typedef struct packed {
      logic       wb, alu, imm, selector, mr, mw, jmp, ior, iow;
      logic [2:0] alu_ops;
      logic [1:0] flag_sel;
      logic [1:0] fd;
      logic       is_stack_op, stack_op, stack_pc, stack_flags;
      logic [1:0] word_idx;
      logic       fetch_stall, int_ack, busy;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] opcode = 8'h00;
   logic       opcode_valid = 1'b0;
   logic       int_req = 1'b0;
   logic       stall_in = 1'b0;
   logic       wb, alu, imm, selector, mr, mw, jmp, ior, iow;
   logic [2:0] alu_ops;
   logic [1:0] flag_sel, fd, word_idx;
   logic       is_stack_op, stack_op, stack_pc, stack_flags;
   logic       fetch_stall, int_ack, busy;
   obs_t       obs;
   int         total = 0;
   int         bad = 0;

   assign obs = {wb, alu, imm, selector, mr, mw, jmp, ior, iow, alu_ops, flag_sel, fd,
                 is_stack_op, stack_op, stack_pc, stack_flags, word_idx,
                 fetch_stall, int_ack, busy};

   always #5 clk = ~clk;

   cu_seq #(.OPCODE_W(8), .PC_WORDS(2), .FLAGS_ON_INT(1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .opcode_valid(opcode_valid),
      .int_req(int_req), .stall_in(stall_in),
      .wb(wb), .alu(alu), .imm(imm), .selector(selector), .mr(mr), .mw(mw),
      .jmp(jmp), .ior(ior), .iow(iow), .alu_ops(alu_ops), .flag_sel(flag_sel),
      .fd(fd), .is_stack_op(is_stack_op), .stack_op(stack_op), .stack_pc(stack_pc),
      .stack_flags(stack_flags), .word_idx(word_idx), .fetch_stall(fetch_stall),
      .int_ack(int_ack), .busy(busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t e;
      rst = 1'b0; opcode = 8'h00; opcode_valid = 1'b1;
      step(); step();
      e = '0;
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset: got %h want %h", obs, e); end
      rst = 1'b1; opcode = 8'h03;
      step();
      e = '0; e.wb = 1'b1; e.alu = 1'b1; e.alu_ops = 3'b011; e.flag_sel = 2'b11; e.fd = 2'b11;
      total++;
      if (obs !== e) begin bad++; $display("FAIL first_decode: got %h want %h", obs, e); end
   endtask

   task automatic test_decode();
      logic [7:0] ops [12];
      obs_t       ex  [12];
      ops = '{8'h4A, 8'h10, 8'h1A, 8'h28, 8'h29, 8'h39, 8'h38, 8'hE1, 8'hE0, 8'h85, 8'h20, 8'h03};
      for (int i = 0; i < 12; i++) ex[i] = '0;
      ex[0].imm = 1'b1; ex[0].mr = 1'b1; ex[0].wb = 1'b1; ex[0].alu_ops = 3'd2; ex[0].flag_sel = 2'd2; ex[0].fd = 2'd2;
      ex[1].mw = 1'b1; ex[1].fd = 2'd2;
      ex[2].jmp = 1'b1; ex[2].alu_ops = 3'd2; ex[2].flag_sel = 2'd2; ex[2].fd = 2'd2;
      ex[3].ior = 1'b1; ex[3].wb = 1'b1; ex[3].fd = 2'd2;
      ex[4].iow = 1'b1; ex[4].alu_ops = 3'd1; ex[4].flag_sel = 2'd1; ex[4].fd = 2'd2;
      ex[5].mr = 1'b1; ex[5].wb = 1'b1; ex[5].is_stack_op = 1'b1; ex[5].stack_op = 1'b1;
      ex[5].alu_ops = 3'd1; ex[5].flag_sel = 2'd1; ex[5].fd = 2'd2;
      ex[6].mw = 1'b1; ex[6].is_stack_op = 1'b1; ex[6].fd = 2'd2;
      ex[7].alu_ops = 3'd1; ex[7].flag_sel = 2'd1; ex[7].fd = 2'b01;
      ex[8].fd = 2'b00;
      ex[9].alu = 1'b1; ex[9].selector = 1'b1; ex[9].wb = 1'b1; ex[9].alu_ops = 3'd5;
      ex[9].flag_sel = 2'd1; ex[9].fd = 2'b11;
      ex[10].wb = 1'b1; ex[10].fd = 2'd2;
      for (int i = 0; i < 12; i++) begin
         opcode = ops[i]; opcode_valid = (i != 11);
         step();
         total++;
         if (obs !== ex[i]) begin
            bad++; $display("FAIL decode_%h: got %h want %h", ops[i], obs, ex[i]);
         end
      end
   endtask

   task automatic test_stall_idle();
      obs_t e;
      obs_t st;
      opcode = 8'h03; opcode_valid = 1'b1; stall_in = 1'b0;
      step();
      e = '0; e.wb = 1'b1; e.alu = 1'b1; e.alu_ops = 3'b011; e.flag_sel = 2'b11; e.fd = 2'b11;
      st = '0; st.mw = 1'b1; st.fd = 2'd2;
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall_pre: got %h want %h", obs, e); end
      stall_in = 1'b1; opcode = 8'h10;
      step();
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall_hold: got %h want %h", obs, e); end
      stall_in = 1'b0;
      step();
      total++;
      if (obs !== st) begin bad++; $display("FAIL stall_release: got %h want %h", obs, st); end
      opcode_valid = 1'b0;
      step();
   endtask

   task automatic test_interrupt();
      obs_t ex [6];
      for (int i = 0; i < 6; i++) ex[i] = '0;
      ex[0].int_ack = 1'b1; ex[0].fetch_stall = 1'b1;
      for (int b = 0; b < 2; b++) begin
         ex[1+b].mw = 1'b1; ex[1+b].stack_pc = 1'b1; ex[1+b].is_stack_op = 1'b1;
         ex[1+b].word_idx = 2'(b); ex[1+b].busy = 1'b1; ex[1+b].fetch_stall = 1'b1;
      end
      ex[3].mw = 1'b1; ex[3].stack_flags = 1'b1; ex[3].is_stack_op = 1'b1;
      ex[3].busy = 1'b1; ex[3].fetch_stall = 1'b1;
      ex[4].mr = 1'b1; ex[4].jmp = 1'b1; ex[4].busy = 1'b1;
      ex[5].wb = 1'b1; ex[5].alu = 1'b1; ex[5].alu_ops = 3'b011; ex[5].flag_sel = 2'b11; ex[5].fd = 2'b11;
      opcode = 8'h03; opcode_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         int_req = (i == 0);
         step();
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL int_seq[%0d]: got %h want %h", i, obs, ex[i]); end
      end
      opcode_valid = 1'b0;
      step();
   endtask

   task automatic test_call();
      obs_t ex [4];
      for (int i = 0; i < 4; i++) ex[i] = '0;
      ex[0].fd = 2'd2; ex[0].fetch_stall = 1'b1;
      for (int b = 0; b < 2; b++) begin
         ex[1+b].mw = 1'b1; ex[1+b].stack_pc = 1'b1; ex[1+b].is_stack_op = 1'b1;
         ex[1+b].word_idx = 2'(b); ex[1+b].busy = 1'b1;
      end
      ex[1].fetch_stall = 1'b1;
      ex[2].jmp = 1'b1; ex[2].flag_sel = 2'b11;
      opcode = 8'hB0; opcode_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         opcode_valid = 1'b0;
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL call_seq[%0d]: got %h want %h", i, obs, ex[i]); end
      end
   endtask

   task automatic test_rti();
      obs_t ex [5];
      for (int i = 0; i < 5; i++) ex[i] = '0;
      ex[0].alu_ops = 3'd1; ex[0].flag_sel = 2'd1; ex[0].fd = 2'd2; ex[0].fetch_stall = 1'b1;
      ex[1].mr = 1'b1; ex[1].stack_flags = 1'b1; ex[1].is_stack_op = 1'b1; ex[1].stack_op = 1'b1;
      ex[1].busy = 1'b1; ex[1].fetch_stall = 1'b1;
      for (int b = 0; b < 2; b++) begin
         ex[2+b].mr = 1'b1; ex[2+b].stack_pc = 1'b1; ex[2+b].is_stack_op = 1'b1;
         ex[2+b].stack_op = 1'b1; ex[2+b].word_idx = 2'(1 - b); ex[2+b].busy = 1'b1;
      end
      ex[2].fetch_stall = 1'b1;
      ex[3].jmp = 1'b1; ex[3].flag_sel = 2'b11;
      opcode = 8'hF1; opcode_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         opcode_valid = 1'b0;
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL rti_seq[%0d]: got %h want %h", i, obs, ex[i]); end
      end
   endtask

   task automatic test_ret_int_stall();
      obs_t ex [7];
      for (int i = 0; i < 7; i++) ex[i] = '0;
      ex[0].fd = 2'd2; ex[0].fetch_stall = 1'b1;
      for (int i = 1; i < 6; i++) begin
         ex[i].mr = 1'b1; ex[i].stack_pc = 1'b1; ex[i].is_stack_op = 1'b1;
         ex[i].stack_op = 1'b1; ex[i].busy = 1'b1;
         ex[i].word_idx = (i < 5) ? 2'd1 : 2'd0;
         ex[i].fetch_stall = (i < 5);
      end
      ex[5].jmp = 1'b1; ex[5].flag_sel = 2'b11;
      ex[6].int_ack = 1'b1; ex[6].fetch_stall = 1'b1;
      opcode = 8'hF0; opcode_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         opcode_valid = (i == 0);
         int_req      = (i == 1);
         stall_in     = (i >= 2) && (i <= 4);
         step();
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL ret_int_seq[%0d]: got %h want %h", i, obs, ex[i]); end
      end
   endtask

   task automatic test_reset_mid();
      obs_t ex [4];
      for (int i = 0; i < 4; i++) ex[i] = '0;
      for (int b = 0; b < 2; b++) begin
         ex[b].mw = 1'b1; ex[b].stack_pc = 1'b1; ex[b].is_stack_op = 1'b1;
         ex[b].word_idx = 2'(b); ex[b].busy = 1'b1; ex[b].fetch_stall = 1'b1;
      end
      opcode_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         int_req = (i == 0);
         rst     = (i != 2);
         step();
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL reset_mid[%0d]: got %h want %h", i, obs, ex[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_stall_idle();
      test_interrupt();
      test_call();
      test_rti();
      test_ret_int_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
